mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 2, cycles from issue edge to valid mem_rdata (legal 1..7).
REQ-002 SHALL have parameter MAX_DATA_STREAK, default 4, consecutive data grants tolerated while fetch waits (legal 1..15).
REQ-003 SHALL use one clock, clk; reset rst is synchronous, active-high.
REQ-004 SHALL have these ports:
 - clk  in  1  clock
 - rst  in  1  sync active-high reset
 - f_req  in  1  fetch read request
 - f_addr  in  32  fetch address
 - f_gnt  out  1  fetch request accepted, 1-cycle pulse
 - f_rvalid  out  1  fetch data valid, 1-cycle pulse
 - f_rdata  out  32  fetch read data
 - d_req  in  1  memory-stage request
 - d_we  in  1  1 = store, 0 = load
 - d_addr  in  32  data address
 - d_wdata  in  32  store data
 - d_gnt  out  1  data request accepted, 1-cycle pulse
 - d_done  out  1  data access complete, 1-cycle pulse
 - d_rdata  out  32  load data
 - mem_en  out  1  memory access strobe
 - mem_we  out  1  memory write enable
 - mem_addr  out  32  memory address
 - mem_wdata  out  32  memory write data
 - mem_rdata  in  32  memory read data
 - busy  out  1  access in flight

Function
REQ-005 SHALL implement states IDLE and WAIT, with at most one access in flight.
REQ-006 SHALL arbitrate only in IDLE; in the issue cycle, drive mem_en=1 and mem_we/mem_addr/mem_wdata combinationally from the winner, and pulse only the winner's gnt.
REQ-007 SHALL drive fetch accesses with mem_we=0 and mem_wdata=0.
REQ-008 SHALL drive mem_we, mem_addr and mem_wdata to 0 whenever mem_en=0.
REQ-009 SHALL require requesters to hold req/addr/we/wdata stable until gnt; the arbiter does not register requests.
REQ-010 SHALL give data priority over fetch, except when streak==MAX_DATA_STREAK and f_req=1, in which case fetch wins.
REQ-011 SHALL update the 4-bit streak counter on grants as follows:
 - fetch grant: clear to 0
 - data grant with f_req=1: increment, saturating at MAX_DATA_STREAK
 - data grant with f_req=0: clear to 0
REQ-012 SHALL, on issue in cycle T, move to WAIT with cnt=MEM_LATENCY, decrementing each cycle.
REQ-013 SHALL, in the WAIT cycle with cnt==1 (cycle T+MEM_LATENCY), sample mem_rdata and return to IDLE.
REQ-014 SHALL pulse f_rvalid (fetch) or d_done (data) from a register in cycle T+MEM_LATENCY+1.
REQ-015 SHALL allow a new issue in that same IDLE cycle; sustained throughput is one access per MEM_LATENCY+1 cycles.
REQ-016 SHALL load f_rdata/d_rdata only on completion of a read of the matching requester and hold them otherwise.
REQ-017 SHALL leave d_rdata unchanged on store completion.
REQ-018 SHALL drive busy=1 exactly while in WAIT.
REQ-019 SHALL ignore requests arriving during WAIT, with no gnt, until IDLE.
REQ-020 SHALL, with f_req and d_req simultaneous in IDLE and streak<MAX_DATA_STREAK, grant data.
REQ-021 SHALL, with no req in IDLE, hold all strobes at 0 and the streak unchanged.

Reset
REQ-022 SHALL, with rst=1 at a clk edge, force IDLE, cnt=0, streak=0, all outputs and data registers 0.
REQ-023 SHALL, on reset during WAIT, abandon the access and issue no f_rvalid/d_done for it afterwards.
REQ-024 SHALL take rst priority over all arbitration in the same cycle.

Verification
REQ-025 SHALL cover fetch-only read, MEM_LATENCY=2: f_addr=0x10 issued cycle 5, mem_rdata=0xDEADBEEF in cycle 7 -> f_gnt cycle 5, f_rvalid cycle 8, f_rdata=0xDEADBEEF.
REQ-026 SHALL cover simultaneous requests in IDLE, streak=0 -> d_gnt first, f_gnt 3 cycles later, streak 0->1->0.
REQ-027 SHALL cover starvation guard: d_req and f_req held high continuously -> 4 d_gnt, then f_gnt, then d_gnt; fetch is never starved beyond 4 data accesses.
REQ-028 SHALL cover store d_we=1, d_addr=0x40, d_wdata=0x5 -> mem_en=1, mem_we=1, mem_addr=0x40, mem_wdata=0x5 in the issue cycle; d_done after 3 cycles; d_rdata unchanged.
REQ-029 SHALL cover rst asserted one cycle after issue -> no rvalid/done ever for that access, busy=0 and all outputs 0 the next cycle.
REQ-030 SHALL cover back-to-back fetches: f_req held high -> f_gnt every 3 cycles, each f_rvalid coinciding with the next f_gnt.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) arbiter in front of a single fixed-latency memory port.
// One access in flight at a time; data has priority, with a streak limit so fetch is never starved.
module mem_port_arbiter #(
    parameter int MEM_LATENCY     = 2,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [2:0] LAT        = 3'(MEM_LATENCY);
    localparam logic [3:0] MAX_STREAK = 4'(MAX_DATA_STREAK);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state_reg, state_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic [3:0]  streak_reg, streak_next;
    logic        own_data_reg, own_data_next;
    logic        own_we_reg, own_we_next;
    logic        f_rvalid_reg, d_done_reg;
    logic [31:0] f_rdata_reg, d_rdata_reg;
    logic        fetch_wins;
    logic        complete;

    // Fetch wins when data is absent or data has used up its streak allowance.
    assign fetch_wins = f_req && (!d_req || (streak_reg == MAX_STREAK));

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        streak_next   = streak_reg;
        own_data_next = own_data_reg;
        own_we_next   = own_we_reg;
        complete      = 1'b0;
        f_gnt         = 1'b0;
        d_gnt         = 1'b0;
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = 32'd0;
        mem_wdata     = 32'd0;
        case (state_reg)
            IDLE: begin
                // Reset in the same cycle suppresses any issue.
                if (!rst && fetch_wins) begin
                    f_gnt         = 1'b1;
                    mem_en        = 1'b1;
                    mem_addr      = f_addr;
                    state_next    = WAIT;
                    cnt_next      = LAT;
                    own_data_next = 1'b0;
                    own_we_next   = 1'b0;
                    streak_next   = 4'd0;
                end else if (!rst && d_req) begin
                    d_gnt         = 1'b1;
                    mem_en        = 1'b1;
                    mem_we        = d_we;
                    mem_addr      = d_addr;
                    mem_wdata     = d_wdata;
                    state_next    = WAIT;
                    cnt_next      = LAT;
                    own_data_next = 1'b1;
                    own_we_next   = d_we;
                    if (!f_req)
                        streak_next = 4'd0;
                    else if (streak_reg != MAX_STREAK)
                        streak_next = streak_reg + 4'd1;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 3'd1;
                if (cnt_reg == 3'd1) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= 3'd0;
            streak_reg   <= 4'd0;
            own_data_reg <= 1'b0;
            own_we_reg   <= 1'b0;
            f_rvalid_reg <= 1'b0;
            d_done_reg   <= 1'b0;
            f_rdata_reg  <= 32'd0;
            d_rdata_reg  <= 32'd0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            streak_reg   <= streak_next;
            own_data_reg <= own_data_next;
            own_we_reg   <= own_we_next;
            f_rvalid_reg <= complete && !own_data_reg;
            d_done_reg   <= complete && own_data_reg;
            if (complete && !own_data_reg)
                f_rdata_reg <= mem_rdata;
            // Stores leave the load data register untouched.
            if (complete && own_data_reg && !own_we_reg)
                d_rdata_reg <= mem_rdata;
        end
    end

    assign f_rvalid = f_rvalid_reg;
    assign d_done   = d_done_reg;
    assign f_rdata  = f_rdata_reg;
    assign d_rdata  = d_rdata_reg;
    assign busy     = (state_reg == WAIT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LATENCY=2, MAX_DATA_STREAK=4.
// Inputs change 1 time unit after each rising edge; outputs are checked 1 unit later.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_gnt;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LATENCY(2), .MAX_DATA_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_strobes(input string tag, input logic fg, input logic dg,
                               input logic fv, input logic dd, input logic bz);
        chk({tag, ".f_gnt"}, {31'd0, f_gnt}, {31'd0, fg});
        chk({tag, ".d_gnt"}, {31'd0, d_gnt}, {31'd0, dg});
        chk({tag, ".f_rvalid"}, {31'd0, f_rvalid}, {31'd0, fv});
        chk({tag, ".d_done"}, {31'd0, d_done}, {31'd0, dd});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, bz});
    endtask

    task automatic chk_mem(input string tag, input logic en, input logic we,
                           input logic [31:0] a, input logic [31:0] wd);
        chk({tag, ".mem_en"}, {31'd0, mem_en}, {31'd0, en});
        chk({tag, ".mem_we"}, {31'd0, mem_we}, {31'd0, we});
        chk({tag, ".mem_addr"}, mem_addr, a);
        chk({tag, ".mem_wdata"}, mem_wdata, wd);
    endtask

    initial begin
        rst = 1'b1; f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0;

        // Reset state, with a request present that must be ignored while rst=1.
        cyc(); f_req = 1'b1; f_addr = 32'h99; #1;
        chk_strobes("rst", 0, 0, 0, 0, 0);
        chk_mem("rst", 0, 0, 0, 0);
        chk("rst.f_rdata", f_rdata, 0);
        chk("rst.d_rdata", d_rdata, 0);
        cyc(); rst = 1'b0; f_req = 1'b0; f_addr = '0; #1;
        chk_strobes("idle", 0, 0, 0, 0, 0);
        chk_mem("idle", 0, 0, 0, 0);

        // Fetch-only read.
        cyc(); f_req = 1'b1; f_addr = 32'h10; #1;
        chk_strobes("fr.T", 1, 0, 0, 0, 0);
        chk_mem("fr.T", 1, 0, 32'h10, 0);
        cyc(); f_req = 1'b0; f_addr = '0; #1;
        chk_strobes("fr.T1", 0, 0, 0, 0, 1);
        chk_mem("fr.T1", 0, 0, 0, 0);
        cyc(); mem_rdata = 32'hDEADBEEF; #1;
        chk_strobes("fr.T2", 0, 0, 0, 0, 1);
        cyc(); mem_rdata = '0; #1;
        chk_strobes("fr.T3", 0, 0, 1, 0, 0);
        chk("fr.f_rdata", f_rdata, 32'hDEADBEEF);
        cyc(); #1;
        chk_strobes("fr.T4", 0, 0, 0, 0, 0);
        chk("fr.f_rdata_hold", f_rdata, 32'hDEADBEEF);

        // Data load.
        cyc(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44; d_wdata = 32'h77; #1;
        chk_strobes("ld.T", 0, 1, 0, 0, 0);
        chk_mem("ld.T", 1, 0, 32'h44, 32'h77);
        cyc(); d_req = 1'b0; d_addr = '0; d_wdata = '0; #1;
        cyc(); mem_rdata = 32'hCAFEF00D; #1;
        cyc(); mem_rdata = '0; #1;
        chk_strobes("ld.T3", 0, 0, 0, 1, 0);
        chk("ld.d_rdata", d_rdata, 32'hCAFEF00D);
        chk("ld.f_rdata", f_rdata, 32'hDEADBEEF);

        // Data store: d_rdata must keep the previous load value.
        cyc(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h5; #1;
        chk_strobes("st.T", 0, 1, 0, 0, 0);
        chk_mem("st.T", 1, 1, 32'h40, 32'h5);
        cyc(); d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; #1;
        chk_mem("st.T1", 0, 0, 0, 0);
        cyc(); mem_rdata = 32'h12345678; #1;
        cyc(); mem_rdata = '0; #1;
        chk_strobes("st.T3", 0, 0, 0, 1, 0);
        chk("st.d_rdata", d_rdata, 32'hCAFEF00D);

        // Simultaneous requests with streak=0: data first, fetch 3 cycles later.
        cyc(); f_req = 1'b1; f_addr = 32'h20; d_req = 1'b1; d_addr = 32'h80; #1;
        chk_strobes("sim.T", 0, 1, 0, 0, 0);
        chk("sim.mem_addr", mem_addr, 32'h80);
        cyc(); d_req = 1'b0; d_addr = '0; d_req = 1'b1; #1;
        chk_strobes("sim.T1", 0, 0, 0, 0, 1);
        cyc(); d_req = 1'b0; #1;
        chk_strobes("sim.T2", 0, 0, 0, 0, 1);
        cyc(); #1;
        chk_strobes("sim.T3", 1, 0, 0, 1, 0);
        chk("sim.T3.mem_addr", mem_addr, 32'h20);
        cyc(); f_req = 1'b0; f_addr = '0; #1;
        cyc(); mem_rdata = 32'hA5A5A5A5; #1;
        cyc(); mem_rdata = '0; #1;
        chk_strobes("sim.T6", 0, 0, 1, 0, 0);
        chk("sim.f_rdata", f_rdata, 32'hA5A5A5A5);

        // Starvation guard: both held; expect d,d,d,d,f,d at 3-cycle spacing.
        cyc(); f_req = 1'b1; f_addr = 32'h30; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h90; #1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                cyc(); #1;
                chk_strobes($sformatf("stv%0d.w1", k), 0, 0, 0, 0, 1);
                cyc(); #1;
                cyc(); #1;
            end
            chk_strobes($sformatf("stv%0d", k), (k == 4), (k != 4),
                        (k == 5), (k > 0 && k != 5), 0);
        end
        cyc(); f_req = 1'b0; d_req = 1'b0; f_addr = '0; d_addr = '0; #1;
        cyc(); #1;
        cyc(); #1;
        chk_strobes("stv.end", 0, 0, 0, 1, 0);

        // Back-to-back fetches: each f_rvalid coincides with the next f_gnt.
        cyc(); f_req = 1'b1; f_addr = 32'h100; #1;
        chk_strobes("b2b0", 1, 0, 0, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            cyc(); #1;
            cyc(); mem_rdata = 32'h1000 + 32'(k); #1;
            cyc(); mem_rdata = '0; #1;
            chk_strobes($sformatf("b2b%0d", k), 1, 0, 1, 0, 0);
            chk($sformatf("b2b%0d.f_rdata", k), f_rdata, 32'h1000 + 32'(k));
        end
        cyc(); f_req = 1'b0; f_addr = '0; #1;
        cyc(); #1;
        cyc(); #1;
        chk_strobes("b2b.end", 0, 0, 1, 0, 0);

        // Reset one cycle after issue abandons the access.
        cyc(); f_req = 1'b1; f_addr = 32'h200; #1;
        chk_strobes("ra.T", 1, 0, 0, 0, 0);
        cyc(); f_req = 1'b0; f_addr = '0; rst = 1'b1; mem_rdata = 32'hBADBAD00; #1;
        cyc(); rst = 1'b0; #1;
        chk_strobes("ra.T2", 0, 0, 0, 0, 0);
        chk_mem("ra.T2", 0, 0, 0, 0);
        chk("ra.f_rdata", f_rdata, 0);
        chk("ra.d_rdata", d_rdata, 0);
        cyc(); #1;
        chk_strobes("ra.T3", 0, 0, 0, 0, 0);
        cyc(); mem_rdata = '0; #1;
        chk_strobes("ra.T4", 0, 0, 0, 0, 0);
        chk("ra.f_rdata_late", f_rdata, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
